wb_gpio_target: RTL and testbench
=================================

WB_GPIO_TARGET -- requirements
Module: wb_gpio_target

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32, number of GPIO pins (1..32).
REQ-002 SHALL have parameter ADDR_LSB, default 2, lowest decoded word-address bit.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wb_addr_i  input  32  Wishbone byte address.
REQ-006 SHALL have port wb_wdata_i  input  32  write data.
REQ-007 SHALL have port wb_rdata_o  output  32  read data, valid while wb_ack_o=1.
REQ-008 SHALL have port wb_wr_en_i  input  1  1=write, 0=read.
REQ-009 SHALL have port wb_byte_en_i  input  4  write byte lanes.
REQ-010 SHALL have port wb_stb_i  input  1  strobe.
REQ-011 SHALL have port wb_cyc_i  input  1  bus cycle.
REQ-012 SHALL have port wb_ack_o  output  1  single-cycle acknowledge.
REQ-013 SHALL have port gpio_i  input  GPIO_WIDTH  asynchronous pin inputs.
REQ-014 SHALL have port gpio_o  output  GPIO_WIDTH  pin output values (OUT register).
REQ-015 SHALL have port gpio_oe_o  output  GPIO_WIDTH  pin output enables (DIR register).
REQ-016 SHALL have port irq_o  output  1  level interrupt.

Function
REQ-017 SHALL decode offset wb_addr_i[ADDR_LSB+2:ADDR_LSB]: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 IRQ_EN (RW), 4 IRQ_STAT (RW1C); 5-7 unmapped.
REQ-018 SHALL implement FSM IDLE/ACK: IDLE and wb_cyc_i&wb_stb_i -> ACK; ACK -> IDLE unconditionally.
REQ-019 SHALL drive wb_ack_o=1 exactly in state ACK, i.e. one cycle after request sampled; one wait state minimum, no back-to-back acks.
REQ-020 SHALL perform write side effects on the IDLE->ACK transition edge, once per transaction.
REQ-021 SHALL update only bytes with wb_byte_en_i[n]=1; bits at or above GPIO_WIDTH ignored on write, read as 0.
REQ-022 SHALL register wb_rdata_o on the IDLE->ACK edge and hold 0 whenever wb_ack_o=0.
REQ-023 SHALL ack unmapped and IN-register writes with no state change; unmapped reads return 0.
REQ-024 SHALL abort cleanly: wb_cyc_i dropped while in ACK -> return to IDLE, no extra effect.
REQ-025 SHALL pass gpio_i through a two-flop synchronizer; IN reads the synchronized value (2-cycle latency).
REQ-026 SHALL set IRQ_STAT[n] on a rising edge of synchronized bit n (current=1, previous=0), regardless of IRQ_EN.
REQ-027 SHALL clear IRQ_STAT[n] on write with wdata bit n=1 in an enabled byte lane; if a new edge occurs the same cycle, the bit SHALL remain 1.
REQ-028 SHALL drive irq_o = |(IRQ_STAT & IRQ_EN) combinationally from registers.
REQ-029 SHALL drive gpio_o=OUT and gpio_oe_o=DIR directly from registers.

Reset
REQ-030 SHALL, on rst_ni=0, asynchronously clear FSM to IDLE, wb_ack_o=0, wb_rdata_o=0, OUT, DIR, IRQ_EN, IRQ_STAT, synchronizer and edge-history flops to 0; gpio_o=0, gpio_oe_o=0, irq_o=0.
REQ-031 SHALL abandon any in-flight transaction on reset; no ack issued for it after release.
REQ-032 SHALL treat a pin high at reset release as a rising edge (history starts at 0).

Structure
REQ-033 SHALL place register offset constants (OUT..IRQ_STAT) and the FSM state enum in shared package wb_gpio_pkg.
REQ-034 SHALL instantiate sub-module sync_2ff (parameterized width, async active-low reset) for the input synchronizer.

Verification
REQ-035 Write OUT=0xA5A5_0F0F, byte_en=4'b0011 after reset -> ack one cycle after stb; gpio_o=0x0000_0F0F; read OUT returns 0x0000_0F0F.
REQ-036 Drive gpio_i=0x0000_0001 -> read IN two+ cycles later returns 0x1; IRQ_STAT=0x1; irq_o=0 until IRQ_EN=0x1 written, then irq_o=1.
REQ-037 Write IRQ_STAT=0x1 while gpio_i[0] toggles 0->1 landing edge same cycle -> IRQ_STAT[0] stays 1; without edge -> clears, irq_o=0.
REQ-038 Read offset 6 (addr 0x18) -> ack, rdata=0; write offset 2 with 0xFFFF_FFFF -> ack, IN unchanged.
REQ-039 Hold cyc&stb high continuously for reads -> ack pattern 0,1,0,1; each ack carries correct data.
REQ-040 Assert rst_ni=0 in IDLE->ACK cycle -> wb_ack_o=0 immediately, all registers 0, no ack after release.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Register map, bus FSM states and byte-lane helper shared by the GPIO target.
// Pure declarations: no latency, no backpressure.
package wb_gpio_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  localparam logic [2:0] OFF_OUT      = 3'd0;
  localparam logic [2:0] OFF_DIR      = 3'd1;
  localparam logic [2:0] OFF_IN       = 3'd2;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
  localparam logic [2:0] OFF_IRQ_STAT = 3'd4;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs; 2-cycle latency.
// No handshake: samples every cycle, never stalls.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/wb_gpio_target.sv
// Wishbone GPIO target: OUT/DIR/IN/IRQ_EN/IRQ_STAT registers; ack one cycle after request.
// Always one wait state, no back-to-back acks; the master is held only by the missing ack.
module wb_gpio_target
  import wb_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = 32,
  parameter int ADDR_LSB   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           wb_addr_i,
  input  logic [31:0]           wb_wdata_i,
  output logic [31:0]           wb_rdata_o,
  input  logic                  wb_wr_en_i,
  input  logic [3:0]            wb_byte_en_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  state_e state_q, state_d;

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] en_q, en_d;
  logic [GPIO_WIDTH-1:0] stat_q, stat_d;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] gpio_sync;
  logic [31:0]           rdata_q, rdata_d;

  logic                  take;
  logic                  wr_go;
  logic [2:0]            offset;
  logic [31:0]           mask32;
  logic [GPIO_WIDTH-1:0] wmask;
  logic [GPIO_WIDTH-1:0] wdata_w;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] stat_clr;
  logic [GPIO_WIDTH-1:0] rd_sel;
  logic                  unused_bits;

  sync_2ff #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (gpio_i),
    .q_o    (gpio_sync)
  );

  assign offset      = wb_addr_i[ADDR_LSB+2:ADDR_LSB];
  assign take        = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign wr_go       = take && wb_wr_en_i;
  assign mask32      = lane_mask(wb_byte_en_i);
  assign wmask       = mask32[GPIO_WIDTH-1:0];
  assign wdata_w     = wb_wdata_i[GPIO_WIDTH-1:0];
  assign unused_bits = ^{wb_addr_i, wb_wdata_i, mask32};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wb_cyc_i && wb_stb_i) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear and a fresh edge in the same cycle leaves the bit set.
  assign rise     = gpio_sync & ~prev_q;
  assign stat_clr = (wr_go && offset == OFF_IRQ_STAT) ? (wdata_w & wmask) : '0;
  assign stat_d   = (stat_q & ~stat_clr) | rise;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    en_d  = en_q;
    if (wr_go) begin
      case (offset)
        OFF_OUT:    out_d = (out_q & ~wmask) | (wdata_w & wmask);
        OFF_DIR:    dir_d = (dir_q & ~wmask) | (wdata_w & wmask);
        OFF_IRQ_EN: en_d  = (en_q  & ~wmask) | (wdata_w & wmask);
        default:    ;
      endcase
    end
  end

  always_comb begin
    rd_sel = '0;
    case (offset)
      OFF_OUT:      rd_sel = out_q;
      OFF_DIR:      rd_sel = dir_q;
      OFF_IN:       rd_sel = gpio_sync;
      OFF_IRQ_EN:   rd_sel = en_q;
      OFF_IRQ_STAT: rd_sel = stat_q;
      default:      rd_sel = '0;
    endcase
    rdata_d = (take && !wb_wr_en_i) ? 32'(rd_sel) : 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      dir_q   <= '0;
      en_q    <= '0;
      stat_q  <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      prev_q  <= gpio_sync;
      rdata_q <= rdata_d;
    end
  end

  assign wb_ack_o   = (state_q == ST_ACK);
  assign wb_rdata_o = rdata_q;
  assign gpio_o     = out_q;
  assign gpio_oe_o  = dir_q;
  assign irq_o      = |(stat_q & en_q);

endmodule

// File: tb/tb_wb_gpio_target.sv
// Bench for wb_gpio_target: behavioural register model checked every cycle,
// plus directed transactions with literal expectations and a random phase.
module tb_wb_gpio_target;

  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [31:0]   wb_addr_i = '0;
  logic [31:0]   wb_wdata_i = '0;
  logic [31:0]   wb_rdata_o;
  logic          wb_wr_en_i = 1'b0;
  logic [3:0]    wb_byte_en_i = '0;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_ack_o;
  logic [GW-1:0] gpio_i = '0;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_oe_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_gpio_target #(.GPIO_WIDTH(GW), .ADDR_LSB(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .wb_addr_i    (wb_addr_i),
    .wb_wdata_i   (wb_wdata_i),
    .wb_rdata_o   (wb_rdata_o),
    .wb_wr_en_i   (wb_wr_en_i),
    .wb_byte_en_i (wb_byte_en_i),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_ack_o     (wb_ack_o),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o),
    .gpio_oe_o    (gpio_oe_o),
    .irq_o        (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus the last three pin samples.
  logic [31:0] m_out = '0, m_dir = '0, m_en = '0, m_stat = '0, m_rdata = '0;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;
  bit          m_ack = 1'b0;

  function automatic logic [31:0] bytes_of(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = be[i / 8];
    return m;
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_rdata = '0;
    p1 = '0; p2 = '0; p3 = '0; m_ack = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] mask, rise, rd, clr;
    int          off;
    bit          take;
    take = !m_ack && wb_cyc_i && wb_stb_i;
    off  = int'(wb_addr_i[4:2]);
    mask = bytes_of(wb_byte_en_i);
    rise = p2 & ~p3;
    rd   = '0;
    clr  = '0;
    if (take && !wb_wr_en_i) begin
      case (off)
        0: rd = m_out;
        1: rd = m_dir;
        2: rd = p2;
        3: rd = m_en;
        4: rd = m_stat;
        default: rd = '0;
      endcase
    end
    if (take && wb_wr_en_i) begin
      case (off)
        0: m_out = (m_out & ~mask) | (wb_wdata_i & mask);
        1: m_dir = (m_dir & ~mask) | (wb_wdata_i & mask);
        3: m_en  = (m_en  & ~mask) | (wb_wdata_i & mask);
        4: clr   = wb_wdata_i & mask;
        default: ;
      endcase
    end
    m_stat  = (m_stat & ~clr) | rise;
    p3      = p2;
    p2      = p1;
    p1      = gpio_i;
    m_ack   = take;
    m_rdata = rd;
  endtask

  // Model advances on rising edges, DUT is compared on falling edges.
  initial begin
    forever begin
      @(posedge clk or negedge clk or negedge rst_ni);
      if (!rst_ni) model_reset();
      else if (clk) model_step();
      if (!clk) begin
        check("cmp_ack",   {31'd0, wb_ack_o}, {31'd0, m_ack});
        check("cmp_rdata", wb_rdata_o, m_rdata);
        check("cmp_gpio",  gpio_o, m_out);
        check("cmp_oe",    gpio_oe_o, m_dir);
        check("cmp_irq",   {31'd0, irq_o}, {31'd0, |(m_stat & m_en)});
      end
    end
  end

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_wr_en_i = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, output logic [31:0] rd, output int lat);
    @(negedge clk);
    #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_wr_en_i = wr;
    wb_addr_i = addr; wb_wdata_i = data; wb_byte_en_i = be;
    rd  = '0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        rd  = wb_rdata_o;
        lat = c;
        break;
      end
    end
    #1;
    idle_bus();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] rd;
    int          lat;
    xfer(1'b1, addr, data, be, rd, lat);
    check("wr_ack_latency", lat, 1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    xfer(1'b0, addr, 32'd0, 4'hF, rd, lat);
    check("rd_ack_latency", lat, 1);
    check(name, rd, exp);
  endtask

  initial begin
    logic [3:0] ack_seq;
    int         acks;

    repeat (3) @(negedge clk);
    check("reset_gpio_o", gpio_o, 32'd0);
    check("reset_oe",     gpio_oe_o, 32'd0);
    check("reset_irq",    {31'd0, irq_o}, 32'd0);
    check("reset_ack",    {31'd0, wb_ack_o}, 32'd0);
    #1 rst_ni = 1'b1;

    // Partial byte-lane write to OUT.
    wr(32'h0, 32'hA5A5_0F0F, 4'b0011);
    check("out_pins", gpio_o, 32'h0000_0F0F);
    rd_chk("out_read", 32'h0, 32'h0000_0F0F);

    // Pin edge raises status; irq only once enabled.
    @(negedge clk); #1 gpio_i = 32'h1;
    repeat (3) @(negedge clk);
    rd_chk("in_read", 32'h8, 32'h1);
    rd_chk("stat_read", 32'h10, 32'h1);
    check("irq_masked", {31'd0, irq_o}, 32'd0);
    wr(32'hC, 32'h1, 4'hF);
    check("irq_enabled", {31'd0, irq_o}, 32'd1);

    // Clear racing a fresh edge keeps the bit.
    @(negedge clk); #1 gpio_i = 32'h0;
    repeat (4) @(negedge clk);
    #1 gpio_i = 32'h1;
    @(negedge clk);
    wr(32'h10, 32'h1, 4'hF);
    rd_chk("stat_kept_on_edge", 32'h10, 32'h1);
    wr(32'h10, 32'h1, 4'hF);
    rd_chk("stat_cleared", 32'h10, 32'h0);
    check("irq_cleared", {31'd0, irq_o}, 32'd0);

    // Unmapped read and IN write.
    rd_chk("unmapped_read", 32'h18, 32'h0);
    wr(32'h8, 32'hFFFF_FFFF, 4'hF);
    rd_chk("in_after_write", 32'h8, 32'h1);
    wr(32'h4, 32'h1234_5678, 4'b1100);
    check("dir_pins", gpio_oe_o, 32'h1234_0000);

    // Request held continuously: ack every other cycle.
    @(negedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_wr_en_i = 1'b0; wb_addr_i = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_seq[3 - i] = wb_ack_o;
      check("held_rdata", wb_rdata_o, (i % 2 == 0) ? 32'h1234_0000 : 32'h0);
    end
    check("held_ack_pattern", {28'd0, ack_seq}, 32'h0000_000A);
    #1 idle_bus();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      wb_cyc_i     = ($urandom_range(0, 3) != 0);
      wb_stb_i     = ($urandom_range(0, 2) != 0);
      wb_wr_en_i   = $urandom_range(0, 1);
      wb_addr_i    = $urandom;
      wb_wdata_i   = $urandom;
      wb_byte_en_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) gpio_i = $urandom;
    end
    @(negedge clk); #1 idle_bus();
    wr(32'h0, 32'hDEAD_BEEF, 4'hF);

    // Reset landing right after a request is accepted.
    @(negedge clk); #1;
    gpio_i = 32'h1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_wr_en_i = 1'b0; wb_addr_i = 32'h0;
    @(posedge clk); #1 rst_ni = 1'b0;
    #1;
    check("rst_ack_now",   {31'd0, wb_ack_o}, 32'd0);
    check("rst_rdata_now", wb_rdata_o, 32'd0);
    check("rst_gpio_now",  gpio_o, 32'd0);
    idle_bus();
    repeat (2) @(negedge clk);
    #1 rst_ni = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    check("no_ack_after_reset", acks, 0);
    rd_chk("edge_at_release", 32'h10, 32'h1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
